// File: rtl/hsv_pkg.sv
// -----------------------------------------------------------------------------
// hsv_pkg
//   Shared constants, the hue sector encoding and the per-stage pipeline
//   record for the RGB->HSV converter (rgb_hsv_stage).
//   Hue is expressed on a 0..255 circle (256 = 360 degrees), so one sector of
//   60 degrees is 43 counts and the G/B sector bases sit at 85 and 171.
// -----------------------------------------------------------------------------
package hsv_pkg;

   localparam logic [7:0] HUE_SECTOR   = 8'd43;
   localparam logic [7:0] HUE_BASE_R   = 8'd0;
   localparam logic [7:0] HUE_BASE_G   = 8'd85;
   localparam logic [7:0] HUE_BASE_B   = 8'd171;

   localparam logic [3:0] PKT_ID_VIDEO = 4'h0;

   // Total register stages from accept to source_valid.
   localparam int HSV_LATENCY = 10;
   // One stage for operand prep, one for output assembly, the rest divide.
   localparam int DIV_STEPS   = HSV_LATENCY - 2;

   typedef enum logic [1:0] {
      SEC_R = 2'd0,
      SEC_G = 2'd1,
      SEC_B = 2'd2
   } sector_t;

   // Record carried down the divider chain. remainder/quotient form the
   // combined shift register of a restoring divider: the quotient field starts
   // out holding the low dividend byte and fills with quotient bits as the
   // dividend bits shift out into the remainder.
   typedef struct packed {
      logic        valid;
      logic        sop;
      logic        eop;
      logic        video;
      logic [23:0] rgb;
      sector_t     sector;
      logic        sign;          // 1 when the hue numerator is negative
      logic [7:0]  div_h;         // hue divisor  = delta
      logic [7:0]  div_s;         // sat divisor  = cmax (also V)
      logic [7:0]  remainder_h;
      logic [7:0]  remainder_s;
      logic [7:0]  quotient_h;
      logic [7:0]  quotient_s;
   } stage_t;

   function automatic logic [7:0] hue_base(input sector_t sec);
      case (sec)
         SEC_G:   return HUE_BASE_G;
         SEC_B:   return HUE_BASE_B;
         default: return HUE_BASE_R;
      endcase
   endfunction

endpackage

// File: rtl/hsv_div_step.sv
// -----------------------------------------------------------------------------
// hsv_div_step
//   One step of an 8-bit-quotient restoring divider: shift the next dividend
//   bit into the partial remainder, trial-subtract the divisor and shift the
//   resulting quotient bit into the quotient register. Purely combinational.
// Ports
//   divisor   in  8  divisor (0 is allowed; the dividend is then 0 as well)
//   rem_in    in  8  partial remainder, always < divisor
//   quo_in    in  8  remaining dividend bits (MSB next) / quotient so far
//   rem_out   out 8  updated partial remainder
//   quo_out   out 8  quo_in shifted left with the new quotient bit in LSB
// -----------------------------------------------------------------------------
module hsv_div_step (
   input  logic [7:0] divisor,
   input  logic [7:0] rem_in,
   input  logic [7:0] quo_in,
   output logic [7:0] rem_out,
   output logic [7:0] quo_out
);

   logic [8:0] trial;
   logic       fits;

   // rem_in < divisor, so 2*rem_in+1 fits in 9 bits and the difference
   // after a successful subtract is again < divisor (fits in 8 bits).
   assign trial = {rem_in, quo_in[7]};

   // A zero divisor only occurs with a zero dividend; forcing the quotient
   // bit low makes the result 0 instead of all ones.
   assign fits    = (divisor != 8'd0) && (trial >= {1'b0, divisor});
   assign rem_out = fits ? 8'(trial - {1'b0, divisor}) : trial[7:0];
   assign quo_out = {quo_in[6:0], fits};

endmodule

// File: rtl/rgb_hsv_stage.sv
// -----------------------------------------------------------------------------
// rgb_hsv_stage
//   Pipelined RGB->HSV converter on an Avalon-ST video path. Each beat's RGB,
//   sop and eop pass through unchanged; an 8-bit H/S/V sideband is attached.
//   Fixed latency of HSV_LATENCY (10) cycles with full backpressure: the whole
//   pipeline advances together whenever the output register is empty or being
//   accepted. Bubbles travel with the data and are not collapsed.
//     S0      : cmax/cmin/delta, hue sector, |numerator|, sign, dividends
//     S1..S8  : hue and saturation restoring dividers, one bit per stage
//     S9      : hue assembly, packet gating, output registers
//   HSV sideband and mask are forced to 0 for sop beats and for every beat of
//   a non-video packet (sop beat with data[3:0] != PKT_ID_VIDEO).
// Configuration
//   HSV_MASK_EN  when defined, source_mask is the registered threshold test
//                H_MIN <= H <= H_MAX, S >= S_MIN, V >= V_MIN (no hue wrap).
//                When undefined, source_mask is tied to 0.
// Ports
//   clk           in   1   clock
//   reset_n       in   1   synchronous active-low reset
//   sink_data     in   24  {R,G,B}
//   sink_valid    in   1   input beat valid
//   sink_ready    out  1   input accepted when sink_valid & sink_ready
//   sink_sop      in   1   start of packet
//   sink_eop      in   1   end of packet
//   source_data   out  24  delayed sink_data
//   source_hsv    out  24  {H,S,V}
//   source_mask   out  1   HSV inside threshold window
//   source_valid  out  1   output beat valid
//   source_ready  in   1   downstream ready
//   source_sop    out  1   delayed sop
//   source_eop    out  1   delayed eop
// -----------------------------------------------------------------------------
module rgb_hsv_stage
   import hsv_pkg::*;
#(
   parameter logic [7:0] H_MIN = 8'd60,
   parameter logic [7:0] H_MAX = 8'd110,
   parameter logic [7:0] S_MIN = 8'd80,
   parameter logic [7:0] V_MIN = 8'd60
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [23:0] sink_data,
   input  logic        sink_valid,
   output logic        sink_ready,
   input  logic        sink_sop,
   input  logic        sink_eop,
   output logic [23:0] source_data,
   output logic [23:0] source_hsv,
   output logic        source_mask,
   output logic        source_valid,
   input  logic        source_ready,
   output logic        source_sop,
   output logic        source_eop
);

   genvar gi;

   logic                    adv;
   logic                    accept;
   logic                    pkt_video_reg;

   stage_t [DIV_STEPS:0]    stage_reg;
   stage_t [DIV_STEPS:1]    step_next;
   stage_t                  s0_next;

   logic                    source_valid_reg;
   logic                    source_sop_reg;
   logic                    source_eop_reg;
   logic [23:0]             source_data_reg;
   logic [23:0]             source_hsv_reg;

   // Output register is free when empty or being taken this cycle.
   assign adv        = ~source_valid_reg | source_ready;
   assign sink_ready = adv;
   assign accept     = sink_valid & adv;

   // ---------------------------------------------------------------------
   // S0: operand preparation
   // ---------------------------------------------------------------------
   logic [7:0]  red, green, blue;
   logic [7:0]  cmax, cmin, delta, abs_num;
   logic        num_neg;
   sector_t     sector;
   logic [15:0] hue_dividend, sat_dividend;
   logic        video_in;

   always_comb begin
      red     = sink_data[23:16];
      green   = sink_data[15:8];
      blue    = sink_data[7:0];
      sector  = SEC_R;
      cmax    = red;
      cmin    = red;
      num_neg = 1'b0;
      abs_num = 8'd0;

      // Ties resolve towards R, then G, then B.
      if (red >= green && red >= blue) begin
         sector  = SEC_R;
         cmax    = red;
         cmin    = (green < blue) ? green : blue;
         num_neg = (green < blue);
         abs_num = (green >= blue) ? green - blue : blue - green;
      end else if (green >= blue) begin
         sector  = SEC_G;
         cmax    = green;
         cmin    = (red < blue) ? red : blue;
         num_neg = (blue < red);
         abs_num = (blue >= red) ? blue - red : red - blue;
      end else begin
         sector  = SEC_B;
         cmax    = blue;
         cmin    = (red < green) ? red : green;
         num_neg = (red < green);
         abs_num = (red >= green) ? red - green : green - red;
      end

      delta        = cmax - cmin;
      hue_dividend = 16'(HUE_SECTOR) * 16'(abs_num);
      sat_dividend = 16'(8'd255) * 16'(delta);

      // The packet type is decided by the sop beat itself and then held.
      video_in = sink_sop ? (sink_data[3:0] == PKT_ID_VIDEO) : pkt_video_reg;

      s0_next             = '0;
      s0_next.valid       = sink_valid;
      s0_next.sop         = sink_sop;
      s0_next.eop         = sink_eop;
      s0_next.video       = video_in;
      s0_next.rgb         = sink_data;
      s0_next.sector      = sector;
      s0_next.sign        = num_neg;
      s0_next.div_h       = delta;
      s0_next.div_s       = cmax;
      // Quotients are known to fit in 8 bits, so the upper dividend byte is
      // already smaller than the divisor and seeds the remainder directly.
      s0_next.remainder_h = hue_dividend[15:8];
      s0_next.quotient_h  = hue_dividend[7:0];
      s0_next.remainder_s = sat_dividend[15:8];
      s0_next.quotient_s  = sat_dividend[7:0];
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pkt_video_reg <= 1'b0;
      end else if (accept && sink_sop) begin
         pkt_video_reg <= (sink_data[3:0] == PKT_ID_VIDEO);
      end
   end

   // ---------------------------------------------------------------------
   // S1..S8: two parallel dividers, one quotient bit per stage
   // ---------------------------------------------------------------------
   generate
      for (gi = 1; gi <= DIV_STEPS; gi++) begin : g_div
         logic [7:0] rem_h, quo_h, rem_s, quo_s;
         stage_t     nxt;

         hsv_div_step u_hue (
            .divisor (stage_reg[gi-1].div_h),
            .rem_in  (stage_reg[gi-1].remainder_h),
            .quo_in  (stage_reg[gi-1].quotient_h),
            .rem_out (rem_h),
            .quo_out (quo_h)
         );

         hsv_div_step u_sat (
            .divisor (stage_reg[gi-1].div_s),
            .rem_in  (stage_reg[gi-1].remainder_s),
            .quo_in  (stage_reg[gi-1].quotient_s),
            .rem_out (rem_s),
            .quo_out (quo_s)
         );

         always_comb begin
            nxt             = stage_reg[gi-1];
            nxt.remainder_h = rem_h;
            nxt.quotient_h  = quo_h;
            nxt.remainder_s = rem_s;
            nxt.quotient_s  = quo_s;
         end

         assign step_next[gi] = nxt;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         stage_reg <= '0;
      end else if (adv) begin
         stage_reg[0]           <= s0_next;
         stage_reg[DIV_STEPS:1] <= step_next;
      end
   end

   // ---------------------------------------------------------------------
   // S9: output assembly
   // ---------------------------------------------------------------------
   stage_t      last;
   logic [7:0]  hue, sat, val;
   logic        pass_hsv;
   logic [23:0] hsv_next;
   logic        unused_tail;

   always_comb begin
      last = stage_reg[DIV_STEPS];
      sat  = last.quotient_s;
      val  = last.div_s;
      // Hue arithmetic wraps on the 256-count circle.
      if (last.div_h == 8'd0) begin
         hue = 8'd0;
      end else if (last.sign) begin
         hue = hue_base(last.sector) - last.quotient_h;
      end else begin
         hue = hue_base(last.sector) + last.quotient_h;
      end
      pass_hsv = last.video & ~last.sop;
      hsv_next = pass_hsv ? {hue, sat, val} : 24'd0;
   end

   // Final remainders are a by-product of the division and are not needed.
   assign unused_tail = ^{last.remainder_h, last.remainder_s};

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         source_valid_reg <= 1'b0;
         source_sop_reg   <= 1'b0;
         source_eop_reg   <= 1'b0;
         source_data_reg  <= 24'd0;
         source_hsv_reg   <= 24'd0;
      end else if (adv) begin
         source_valid_reg <= last.valid;
         source_sop_reg   <= last.sop;
         source_eop_reg   <= last.eop;
         source_data_reg  <= last.rgb;
         source_hsv_reg   <= hsv_next;
      end
   end

`ifdef HSV_MASK_EN
   logic mask_reg;
   logic mask_next;

   assign mask_next = pass_hsv &&
                      (hue >= H_MIN) && (hue <= H_MAX) &&
                      (sat >= S_MIN) && (val >= V_MIN);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         mask_reg <= 1'b0;
      end else if (adv) begin
         mask_reg <= mask_next;
      end
   end

   assign source_mask = mask_reg;
`else
   logic unused_mask_cfg;
   assign unused_mask_cfg = ^{H_MIN, H_MAX, S_MIN, V_MIN};
   assign source_mask     = 1'b0;
`endif

   assign source_valid = source_valid_reg;
   assign source_sop   = source_sop_reg;
   assign source_eop   = source_eop_reg;
   assign source_data  = source_data_reg;
   assign source_hsv   = source_hsv_reg;

endmodule

// File: tb/tb_rgb_hsv_stage.sv
// -----------------------------------------------------------------------------
// tb_rgb_hsv_stage
//   Scoreboard bench for rgb_hsv_stage. The stimulus side pushes the expected
//   output of every accepted beat (computed by an integer HSV model); an
//   independent monitor pops and compares whenever an output beat transfers,
//   and checks that outputs hold while stalled.
// -----------------------------------------------------------------------------
module tb_rgb_hsv_stage;

   localparam logic [7:0] T_HMIN = 8'd60;
   localparam logic [7:0] T_HMAX = 8'd110;
   localparam logic [7:0] T_SMIN = 8'd80;
   localparam logic [7:0] T_VMIN = 8'd60;
`ifdef HSV_MASK_EN
   localparam bit MASK_EN = 1'b1;
`else
   localparam bit MASK_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n;
   logic [23:0] sink_data;
   logic        sink_valid;
   logic        sink_ready;
   logic        sink_sop;
   logic        sink_eop;
   logic [23:0] source_data;
   logic [23:0] source_hsv;
   logic        source_mask;
   logic        source_valid;
   logic        source_ready;
   logic        source_sop;
   logic        source_eop;

   always #5 clk = ~clk;

   rgb_hsv_stage #(
      .H_MIN(T_HMIN), .H_MAX(T_HMAX), .S_MIN(T_SMIN), .V_MIN(T_VMIN)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .sink_data    (sink_data),
      .sink_valid   (sink_valid),
      .sink_ready   (sink_ready),
      .sink_sop     (sink_sop),
      .sink_eop     (sink_eop),
      .source_data  (source_data),
      .source_hsv   (source_hsv),
      .source_mask  (source_mask),
      .source_valid (source_valid),
      .source_ready (source_ready),
      .source_sop   (source_sop),
      .source_eop   (source_eop)
   );

   typedef struct {
      logic [23:0] data;
      logic        sop;
      logic        eop;
      logic [23:0] hsv;
      logic        mask;
      int          acc_cyc;
      bit          chk_lat;
   } exp_t;

   exp_t sb[$];
   int   n_checks   = 0;
   int   n_pass     = 0;
   int   cyc        = 0;
   bit   rand_ready = 1'b0;
   bit   pkt_video  = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h required %0h", name, act, req);
   endtask

   // Reference HSV in plain integer arithmetic; returns {mask, H, S, V}.
   function automatic logic [24:0] ref_pixel(input logic [23:0] px);
      int r, g, b, mx, mn, d, h, s, v, num, base, q;
      logic m;
      r  = int'(px[23:16]);
      g  = int'(px[15:8]);
      b  = int'(px[7:0]);
      mx = (r > g) ? r : g;  mx = (mx > b) ? mx : b;
      mn = (r < g) ? r : g;  mn = (mn < b) ? mn : b;
      d  = mx - mn;
      v  = mx;
      s  = (mx == 0) ? 0 : (255 * d) / mx;
      if (d == 0) begin
         h = 0;
      end else begin
         if (r == mx)      begin base = 0;   num = g - b; end
         else if (g == mx) begin base = 85;  num = b - r; end
         else              begin base = 171; num = r - g; end
         q = (43 * ((num < 0) ? -num : num)) / d;
         h = (num >= 0) ? base + q : base - q;
         h = (h + 256) % 256;
      end
      m = MASK_EN && (h >= int'(T_HMIN)) && (h <= int'(T_HMAX)) &&
          (s >= int'(T_SMIN)) && (v >= int'(T_VMIN));
      return {m, 8'(h), 8'(s), 8'(v)};
   endfunction

   // Present one beat; push its expectation at the negedge before the edge
   // that accepts it. Returns just after that edge with sink_valid low.
   task automatic send_beat(input logic [23:0] data, input bit sop, input bit eop, input bit chk_lat);
      exp_t       e;
      logic [24:0] m;
      int         waitc;
      bit         done;
      sink_data  = data;
      sink_sop   = sop;
      sink_eop   = eop;
      sink_valid = 1'b1;
      waitc      = 0;
      done       = 1'b0;
      while (!done) begin
         @(negedge clk);
         if (sink_ready && reset_n) begin
            if (sop) pkt_video = (data[3:0] == 4'h0);
            m         = ref_pixel(data);
            e.data    = data;
            e.sop     = sop;
            e.eop     = eop;
            e.hsv     = (pkt_video && !sop) ? m[23:0] : 24'd0;
            e.mask    = (pkt_video && !sop) ? m[24] : 1'b0;
            e.acc_cyc = cyc;
            e.chk_lat = chk_lat;
            sb.push_back(e);
            done = 1'b1;
         end else begin
            waitc++;
            if (waitc > 200) begin
               n_checks++;
               $display("FAIL accept_timeout: got no sink_ready in 200 cycles, required acceptance");
               done = 1'b1;
            end
         end
         @(posedge clk); #1;
      end
      sink_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      sink_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input int budget);
      int k;
      k = 0;
      while (sb.size() != 0 && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("drain_queue_size", 64'(sb.size()), 64'd0);
      @(posedge clk); #1;
   endtask

   // Downstream ready: constant high, or random with 1- and 5-cycle holds.
   initial begin
      int hold;
      int k;
      hold         = 0;
      source_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (!rand_ready) begin
            source_ready = 1'b1;
            hold         = 0;
         end else if (hold > 0) begin
            source_ready = 1'b0;
            hold--;
         end else begin
            k = $urandom_range(0, 9);
            if (k == 0) begin
               source_ready = 1'b0;
               hold         = 4;
            end else if (k <= 3) begin
               source_ready = 1'b0;
            end else begin
               source_ready = 1'b1;
            end
         end
      end
   end

   // Monitor: compares each transferred beat and stall stability.
   initial begin
      exp_t        e;
      bit          stall_prev;
      logic [51:0] held;
      stall_prev = 1'b0;
      held       = '0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            stall_prev = 1'b0;
         end else begin
            if (stall_prev)
               check("stall_hold",
                     {source_valid, source_sop, source_eop, source_mask, source_data, source_hsv},
                     held);
            if (source_valid && source_ready) begin
               if (sb.size() == 0) begin
                  n_checks++;
                  $display("FAIL unexpected_beat: got data %h, required no beat", source_data);
               end else begin
                  e = sb.pop_front();
                  check("beat",
                        {source_sop, source_eop, source_mask, source_data, source_hsv},
                        {e.sop, e.eop, e.mask, e.data, e.hsv});
                  if (e.chk_lat) check("latency", 64'(cyc - e.acc_cyc), 64'd10);
               end
            end
            stall_prev = source_valid && !source_ready;
            held       = {source_valid, source_sop, source_eop, source_mask, source_data, source_hsv};
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: got no end of test by 1ms, required completion");
      $fatal(1, "watchdog");
   end

   logic [23:0] dir_px [11];
   logic [23:0] nv_px  [3];

   initial begin
      logic [23:0] d;
      dir_px = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFF00, 24'hFF0080,
                 24'h646464, 24'h000000, 24'h28C83C, 24'hC8283C, 24'h00FFFF,
                 24'h102030};
      nv_px  = '{24'hFF0000, 24'h00FF00, 24'h0A141E};

      reset_n    = 1'b0;
      sink_valid = 1'b0;
      sink_data  = 24'd0;
      sink_sop   = 1'b0;
      sink_eop   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check("reset_outputs",
            {source_valid, source_sop, source_eop, source_mask, source_data, source_hsv}, 64'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(negedge clk);
      check("reset_sink_ready", sink_ready, 1'b1);
      @(posedge clk); #1;

      // Directed pixels in a video packet, ready held high, latency checked.
      send_beat(24'h123450, 1'b1, 1'b0, 1'b1);
      foreach (dir_px[i]) send_beat(dir_px[i], 1'b0, (i == 10), 1'b1);
      wait_drain(100);

      // Non-video packet: hsv and mask forced to 0, data untouched.
      send_beat(24'hABCDEF, 1'b1, 1'b0, 1'b1);
      foreach (nv_px[i]) send_beat(nv_px[i], 1'b0, (i == 2), 1'b1);
      // Following video packet restores the sideband.
      send_beat(24'h555550, 1'b1, 1'b0, 1'b1);
      send_beat(24'hFF0080, 1'b0, 1'b0, 1'b1);
      send_beat(24'h28C83C, 1'b0, 1'b1, 1'b1);
      wait_drain(100);

      // 640-beat line with random gaps and random backpressure.
      rand_ready = 1'b1;
      for (int i = 0; i < 640; i++) begin
         if ($urandom_range(0, 3) == 0) idle(1);
         d = 24'($urandom);
         if (i == 0) d[3:0] = 4'h0;
         send_beat(d, (i == 0), (i == 639), 1'b0);
      end
      rand_ready = 1'b0;
      wait_drain(400);

      // Reset in the middle of a frame with beats at the output.
      send_beat(24'h000000, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 14; i++) send_beat(24'($urandom), 1'b0, 1'b0, 1'b0);
      reset_n = 1'b0;
      @(negedge clk);
      check("pre_reset_valid", source_valid, 1'b1);
      @(posedge clk); #1;
      @(negedge clk);
      check("mid_reset_outputs",
            {source_valid, source_sop, source_eop, source_mask, source_data, source_hsv}, 64'd0);
      sb.delete();
      pkt_video = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      idle(2);

      // Operation after reset.
      send_beat(24'h777770, 1'b1, 1'b0, 1'b1);
      send_beat(24'h28C83C, 1'b0, 1'b0, 1'b1);
      send_beat(24'hC8283C, 1'b0, 1'b0, 1'b1);
      send_beat(24'($urandom), 1'b0, 1'b1, 1'b1);
      wait_drain(100);
      idle(20);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
